// File: rtl/simt_scheduler_pkg.sv
// gpu_pkg: shared types and encodings for the SIMT core scheduler.
// Holds the core FSM state enum plus fetcher and LSU status codes.
package gpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } core_state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQUESTING  = 2'b01;
    localparam logic [1:0] LSU_WAITING     = 2'b10;

endpackage

// File: rtl/simt_scheduler_if.sv
// simt_scheduler_if: bundle between the scheduler and its core neighbours.
// slave = scheduler side; master = fetcher/decoder/LSU/ALU side.
// Inputs : start, thread_count, decoded_*, fetcher_state, lsu_state, next_pc
// Outputs: current_pc, active_mask, core_state, done
//          (+ perf_cycles/perf_instrs/perf_diverge with SIMT_SCHED_PERF_EN)
interface simt_scheduler_if #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
);
    localparam int T       = THREADS_PER_BLOCK;
    localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1;

    logic                          start;
    logic [TC_BITS-1:0]            thread_count;
    logic                          decoded_mem_read_enable;
    logic                          decoded_mem_write_enable;
    logic                          decoded_ret;
    logic [2:0]                    fetcher_state;
    logic [T-1:0][1:0]             lsu_state;
    logic [T-1:0][PC_BITS-1:0]     next_pc;
    logic [PC_BITS-1:0]            current_pc;
    logic [T-1:0]                  active_mask;
    logic [2:0]                    core_state;
    logic                          done;
`ifdef SIMT_SCHED_PERF_EN
    logic [31:0]                   perf_cycles;
    logic [31:0]                   perf_instrs;
    logic [15:0]                   perf_diverge;
`endif

    modport slave (
        input  start, thread_count,
        input  decoded_mem_read_enable, decoded_mem_write_enable,
        input  decoded_ret, fetcher_state, lsu_state, next_pc,
`ifdef SIMT_SCHED_PERF_EN
        output perf_cycles, perf_instrs, perf_diverge,
`endif
        output current_pc, active_mask, core_state, done
    );

    modport master (
        output start, thread_count,
        output decoded_mem_read_enable, decoded_mem_write_enable,
        output decoded_ret, fetcher_state, lsu_state, next_pc,
`ifdef SIMT_SCHED_PERF_EN
        input  perf_cycles, perf_instrs, perf_diverge,
`endif
        input  current_pc, active_mask, core_state, done
    );

endinterface

// File: rtl/simt_scheduler_min.sv
// pc_min_select: finds the smallest PC among valid lanes and flags every lane at it.
// Ports: pc_i[T], valid_i[T] -> min_pc_o, match_mask_o[T], any_valid_o.
module pc_min_select #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] pc_i,
    input  logic [THREADS_PER_BLOCK-1:0]              valid_i,
    output logic [PC_BITS-1:0]                        min_pc_o,
    output logic [THREADS_PER_BLOCK-1:0]              match_mask_o,
    output logic                                      any_valid_o
);
    logic [PC_BITS-1:0] m;
    logic               a;

    always_comb begin
        m = '0;
        a = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (valid_i[i] && (!a || pc_i[i] < m)) begin
                m = pc_i[i];
                a = 1'b1;
            end
        end
    end

    // Ties select every matching lane, which is what reconverges lanes.
    always_comb begin
        match_mask_o = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            match_mask_o[i] = valid_i[i] && (pc_i[i] == m);
        end
    end

    assign min_pc_o    = m;
    assign any_valid_o = a;

endmodule

// File: rtl/simt_scheduler.sv
// simt_scheduler: per-core FETCH..UPDATE control FSM with per-lane PCs and
// min-PC divergence/reconvergence. Optional perf counters: SIMT_SCHED_PERF_EN.
// Ports: clk, reset (async, active-high), bus (simt_scheduler_if.slave).
module simt_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic              clk,
    input  logic              reset,
    simt_scheduler_if.slave   bus
);
    localparam int T       = THREADS_PER_BLOCK;
    localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1;
    localparam logic [TC_BITS-1:0] T_TC = TC_BITS'(T);

    core_state_t               state_q, state_d;
    logic [PC_BITS-1:0]        cur_pc_q, cur_pc_d;
    logic [T-1:0]              mask_q, mask_d;
    logic [T-1:0]              dmask_q, dmask_d;
    logic                      done_q, done_d;
    logic [T-1:0][PC_BITS-1:0] tpc_q, tpc_d;

    logic [TC_BITS-1:0]        tc_eff;
    logic [T-1:0]              en;
    logic [T-1:0][PC_BITS-1:0] pc_new;
    logic [T-1:0]              done_new;
    logic [T-1:0]              live;
    logic [T-1:0]              busy;
    logic [PC_BITS-1:0]        min_pc;
    logic [T-1:0]              match;
    logic                      any_live;

    always_comb begin
        tc_eff = (bus.thread_count > T_TC) ? T_TC : bus.thread_count;
        for (int i = 0; i < T; i++) begin
            en[i]       = TC_BITS'(i) < tc_eff;
            pc_new[i]   = mask_q[i] ? bus.next_pc[i] : tpc_q[i];
            done_new[i] = dmask_q[i] | (mask_q[i] & bus.decoded_ret);
            // Only lanes executing this instruction may stall WAIT.
            busy[i]     = mask_q[i] &
                          ((bus.lsu_state[i] == LSU_REQUESTING) ||
                           (bus.lsu_state[i] == LSU_WAITING));
        end
    end

    assign live = ~done_new;

    pc_min_select #(
        .THREADS_PER_BLOCK (T),
        .PC_BITS           (PC_BITS)
    ) u_min (
        .pc_i         (pc_new),
        .valid_i      (live),
        .min_pc_o     (min_pc),
        .match_mask_o (match),
        .any_valid_o  (any_live)
    );

    always_comb begin
        state_d  = state_q;
        cur_pc_d = cur_pc_q;
        mask_d   = mask_q;
        dmask_d  = dmask_q;
        done_d   = done_q;
        tpc_d    = tpc_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tpc_d    = '0;
                    cur_pc_d = '0;
                    mask_d   = en;
                    dmask_d  = ~en;
                    if (tc_eff != '0) begin
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (bus.fetcher_state == FETCHER_FETCHED) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_REQUEST;
            S_REQUEST: begin
                if (bus.decoded_mem_read_enable ||
                    bus.decoded_mem_write_enable) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_WAIT: begin
                if (busy == '0) begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                tpc_d   = pc_new;
                dmask_d = done_new;
                if (!any_live) begin
                    done_d  = 1'b1;
                    mask_d  = '0;
                    state_d = S_DONE;
                end else begin
                    cur_pc_d = min_pc;
                    mask_d   = match;
                    state_d  = S_FETCH;
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cur_pc_q <= '0;
            mask_q   <= '0;
            dmask_q  <= '1;
            done_q   <= 1'b0;
            tpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_pc_q <= cur_pc_d;
            mask_q   <= mask_d;
            dmask_q  <= dmask_d;
            done_q   <= done_d;
            tpc_q    <= tpc_d;
        end
    end

    assign bus.current_pc  = cur_pc_q;
    assign bus.active_mask = mask_q;
    assign bus.core_state  = state_q;
    assign bus.done        = done_q;

`ifdef SIMT_SCHED_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] ins_q;
    logic [15:0] div_q;
    logic        launch;
    logic        diverged;

    assign launch   = (state_q == S_IDLE) && bus.start;
    // The new mask is empty when all lanes finish, and so is ~done'.
    assign diverged = (any_live ? match : '0) != live;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
            div_q <= '0;
        end else if (launch) begin
            cyc_q <= '0;
            ins_q <= '0;
            div_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_DONE && cyc_q != '1) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (state_q == S_UPDATE) begin
                if (ins_q != '1) begin
                    ins_q <= ins_q + 32'd1;
                end
                if (diverged && div_q != '1) begin
                    div_q <= div_q + 16'd1;
                end
            end
        end
    end

    assign bus.perf_cycles  = cyc_q;
    assign bus.perf_instrs  = ins_q;
    assign bus.perf_diverge = div_q;
`endif

endmodule

// File: tb/tb_simt_scheduler.sv
// tb_simt_scheduler: drives fetcher/decoder/LSU around simt_scheduler and
// checks PC/mask/state against a lane-level model of the block's program.
module tb_simt_scheduler;
    import gpu_pkg::*;

    localparam int T  = 4;
    localparam int NP = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simt_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_BITS(8)) bus ();

    simt_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int nxt_tab [T][NP];
    bit ret_tab [NP];
    bit mem_tab [NP];
    int mpc     [T];
    bit mdone   [T];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_linear(input int retpc);
        for (int p = 0; p < NP; p++) begin
            for (int l = 0; l < T; l++) nxt_tab[l][p] = (p + 1 < NP) ? p + 1 : p;
            ret_tab[p] = (p >= retpc);
            mem_tab[p] = 1'b0;
        end
    endtask

    task automatic set_random();
        for (int p = 0; p < NP; p++) begin
            for (int l = 0; l < T; l++) nxt_tab[l][p] = p + 1 + $urandom_range(0, 2);
            ret_tab[p] = (p >= 10) || ($urandom_range(0, 7) == 0);
            mem_tab[p] = $urandom_range(0, 1) == 1;
        end
    endtask

    // Lowest PC among unfinished lanes and which lanes sit there.
    task automatic model_sel(output int pc, output logic [3:0] m, output bit all);
        all = 1'b1;
        pc  = 1 << 30;
        m   = '0;
        for (int l = 0; l < T; l++) begin
            if (!mdone[l]) begin
                all = 1'b0;
                if (mpc[l] < pc) pc = mpc[l];
            end
        end
        for (int l = 0; l < T; l++) if (!mdone[l] && mpc[l] == pc) m[l] = 1'b1;
    endtask

    task automatic clear_inputs();
        bus.fetcher_state            = 3'b000;
        bus.decoded_mem_read_enable  = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
        bus.decoded_ret              = 1'b0;
        bus.lsu_state                = '0;
    endtask

    task automatic run_block(input int tc, input bit rst_in_wait);
        int         tce, epc, d, s, w, busy_l;
        logic [3:0] emask;
        bit         all, mem;
        tce = (tc > T) ? T : tc;
        for (int l = 0; l < T; l++) begin
            mpc[l]   = 0;
            mdone[l] = (l >= tce);
        end
        all = 1'b0;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.thread_count = 3'(tc);
        @(negedge clk);
        if (tce == 0) begin
            check("tc0_state", 32'(bus.core_state), 32'(S_DONE));
            check("tc0_done", 32'(bus.done), 32'd1);
        end else begin
            for (int n = 0; n < 64; n++) begin
                model_sel(epc, emask, all);
                check("fetch_state", 32'(bus.core_state), 32'(S_FETCH));
                check("fetch_pc", 32'(bus.current_pc), 32'(epc));
                check("fetch_mask", 32'(bus.active_mask), 32'(emask));
                d = $urandom_range(0, 2);
                repeat (d) @(negedge clk);
                check("fetch_hold", 32'(bus.core_state), 32'(S_FETCH));
                mem = mem_tab[epc];
                s   = $urandom_range(0, 1);
                bus.fetcher_state            = FETCHER_FETCHED;
                bus.decoded_mem_read_enable  = mem && (s == 1);
                bus.decoded_mem_write_enable = mem && (s == 0);
                bus.decoded_ret              = ret_tab[epc];
                for (int l = 0; l < T; l++)
                    bus.next_pc[l] = emask[l] ? 8'(nxt_tab[l][epc])
                                              : 8'($urandom_range(0, 255));
                @(negedge clk);
                check("decode", 32'(bus.core_state), 32'(S_DECODE));
                bus.fetcher_state = 3'b000;
                @(negedge clk);
                check("request", 32'(bus.core_state), 32'(S_REQUEST));
                s      = $urandom_range(0, 5);
                busy_l = 0;
                for (int l = 0; l < T; l++) begin
                    if (emask[l] && ($urandom_range(0, 1) == 1 || busy_l == 0))
                        busy_l = l;
                    bus.lsu_state[l] = emask[l] ? 2'b00 : LSU_REQUESTING;
                end
                if (mem && s > 0)
                    bus.lsu_state[busy_l] = ($urandom_range(0, 1) == 1)
                                            ? LSU_WAITING : LSU_REQUESTING;
                @(negedge clk);
                if (mem) begin
                    w = 0;
                    while (bus.core_state == 3'(S_WAIT) && w < 20) begin
                        w++;
                        if (rst_in_wait) begin
                            bus.start = 1'b0;
                            reset = 1'b1;
                            #1;
                            check("rst_state", 32'(bus.core_state), 32'(S_IDLE));
                            check("rst_pc", 32'(bus.current_pc), 32'd0);
                            check("rst_mask", 32'(bus.active_mask), 32'd0);
                            check("rst_done", 32'(bus.done), 32'd0);
                            clear_inputs();
                            @(negedge clk);
                            reset = 1'b0;
                            @(negedge clk);
                            check("rst_idle", 32'(bus.core_state), 32'(S_IDLE));
                            return;
                        end
                        if (w >= s) bus.lsu_state[busy_l] = 2'b00;
                        @(negedge clk);
                    end
                    check("wait_len", 32'(w), 32'((s == 0) ? 1 : s));
                end
                check("execute", 32'(bus.core_state), 32'(S_EXECUTE));
                check("exec_pc", 32'(bus.current_pc), 32'(epc));
                check("exec_mask", 32'(bus.active_mask), 32'(emask));
                bus.lsu_state = '0;
                @(negedge clk);
                check("update", 32'(bus.core_state), 32'(S_UPDATE));
                check("upd_mask", 32'(bus.active_mask), 32'(emask));
                for (int l = 0; l < T; l++) begin
                    if (emask[l]) begin
                        mpc[l] = nxt_tab[l][epc];
                        if (ret_tab[epc]) mdone[l] = 1'b1;
                    end
                end
                @(negedge clk);
                clear_inputs();
                model_sel(epc, emask, all);
                if (all) break;
            end
            check("finished", 32'(all), 32'd1);
            check("done_state", 32'(bus.core_state), 32'(S_DONE));
            check("done_flag", 32'(bus.done), 32'd1);
            check("done_mask", 32'(bus.active_mask), 32'd0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("back_idle", 32'(bus.core_state), 32'(S_IDLE));
        check("done_clr", 32'(bus.done), 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.thread_count = '0;
        bus.next_pc      = '0;
        clear_inputs();
        #1;
        check("init_state", 32'(bus.core_state), 32'(S_IDLE));
        check("init_pc", 32'(bus.current_pc), 32'd0);
        check("init_mask", 32'(bus.active_mask), 32'd0);
        check("init_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        set_linear(3);
        run_block(4, 1'b0);

        set_linear(6);
        nxt_tab[0][1] = 5; nxt_tab[1][1] = 5;
        nxt_tab[2][1] = 2; nxt_tab[3][1] = 2;
        nxt_tab[2][2] = 5; nxt_tab[3][2] = 5;
        run_block(4, 1'b0);

        set_linear(2);
        run_block(3, 1'b0);
        run_block(0, 1'b0);
        run_block(7, 1'b0);

        set_linear(3);
        mem_tab[0] = 1'b1;
        mem_tab[2] = 1'b1;
        run_block(4, 1'b0);

        set_linear(NP);
        nxt_tab[0][1] = 4; nxt_tab[1][1] = 4;
        nxt_tab[2][1] = 2; nxt_tab[3][1] = 2;
        nxt_tab[2][2] = 6; nxt_tab[3][2] = 6;
        ret_tab[4] = 1'b1;
        ret_tab[6] = 1'b1;
        run_block(4, 1'b0);

        set_linear(3);
        mem_tab[0] = 1'b1;
        run_block(4, 1'b1);
        run_block(4, 1'b0);

        repeat (25) begin
            set_random();
            run_block($urandom_range(0, 5), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
